// File: rtl/wb_shadow_checker.sv
// wb_shadow_checker
//   Mirrors every register-file writeback of a processor run into a shadow
//   array. When the program halts or a cycle budget expires, it walks a
//   loadable table of expected (register, value) pairs and reports the first
//   mismatch. Intended for self-checking CPU runs on FPGA and in simulation.
//
// Ports
//   clock      : single clock, all state on the rising edge
//   reset      : asynchronous, active-low; clears all state including the table
//   start      : pulse, begins a run (honoured in IDLE/DONE only)
//   halt       : program finished, ends RUN
//   wb_en      : regfile write enable
//   wb_reg     : regfile write index
//   wb_data    : regfile write data
//   chk_wr     : load a table entry (honoured in IDLE/DONE only)
//   chk_idx    : table entry index
//   chk_valid  : entry enable, 0 clears the entry
//   chk_reg    : register the entry checks
//   chk_exp    : value the entry expects
//   busy       : high in CLEAR/RUN/CHECK
//   done       : high in DONE
//   pass       : valid with done; all valid entries matched and no timeout
//   timed_out  : RUN ended by the cycle budget rather than halt
//   fail_idx   : first failing entry index
//   fail_got   : shadow value seen by the first failing entry
//   wr_count   : accepted writebacks this run, saturating at 16'hFFFF
//
// NUM_REGS and NUM_CHECKS are expected to be at least 2, TIMEOUT at least 1.
module wb_shadow_checker #(
  parameter  int NUM_REGS   = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_CHECKS = 16,
  parameter  int TIMEOUT    = 200,
  localparam int RW         = $clog2(NUM_REGS),
  localparam int CW         = $clog2(NUM_CHECKS),
  localparam int TW         = $clog2(TIMEOUT + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  wb_en,
  input  logic [RW-1:0]         wb_reg,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  chk_wr,
  input  logic [CW-1:0]         chk_idx,
  input  logic                  chk_valid,
  input  logic [RW-1:0]         chk_reg,
  input  logic [DATA_WIDTH-1:0] chk_exp,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timed_out,
  output logic [CW-1:0]         fail_idx,
  output logic [DATA_WIDTH-1:0] fail_got,
  output logic [15:0]           wr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  // Range limits are one bit wider than the index so the comparison stays
  // meaningful when the array depth is not a power of two.
  localparam logic [RW:0]   NumRegsExt   = (RW + 1)'(NUM_REGS);
  localparam logic [CW:0]   NumChecksExt = (CW + 1)'(NUM_CHECKS);
  localparam logic [CW-1:0] LastCheck    = CW'(NUM_CHECKS - 1);
  localparam logic [TW-1:0] TimeoutLast  = TW'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shadow_q    [NUM_REGS];
  logic                    tbl_valid_q [NUM_CHECKS];
  logic [RW-1:0]           tbl_reg_q   [NUM_CHECKS];
  logic [DATA_WIDTH-1:0]   tbl_exp_q   [NUM_CHECKS];

  logic [15:0]             wr_count_q, wr_count_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [CW-1:0]           ptr_q, ptr_d;
  logic                    pass_q, pass_d;
  logic                    timed_out_q, timed_out_d;
  logic [CW-1:0]           fail_idx_q, fail_idx_d;
  logic [DATA_WIDTH-1:0]   fail_got_q, fail_got_d;

  logic                    shadow_clr;
  logic                    shadow_we;
  logic                    tbl_we;
  logic                    wb_accept;
  logic                    chk_idx_ok;
  logic [RW-1:0]           cur_reg;
  logic                    cur_reg_ok;
  logic [DATA_WIDTH-1:0]   cur_val;
  logic                    cur_mismatch;

  // Writebacks to register 0 or past the register file are not architectural
  // and are dropped without counting.
  assign wb_accept  = wb_en && (wb_reg != '0) && ({1'b0, wb_reg} < NumRegsExt);
  assign chk_idx_ok = ({1'b0, chk_idx} < NumChecksExt);

  // Entry under inspection during CHECK. Register 0 is never written, so its
  // shadow slot stays zero and the hard-wired-zero comparison falls out.
  assign cur_reg      = tbl_reg_q[ptr_q];
  assign cur_reg_ok   = ({1'b0, cur_reg} < NumRegsExt);
  assign cur_val      = cur_reg_ok ? shadow_q[cur_reg] : '0;
  assign cur_mismatch = tbl_valid_q[ptr_q] && (cur_val != tbl_exp_q[ptr_q]);

  // State and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_count_q  <= '0;
      timer_q     <= '0;
      ptr_q       <= '0;
      pass_q      <= 1'b0;
      timed_out_q <= 1'b0;
      fail_idx_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_count_q  <= wr_count_d;
      timer_q     <= timer_d;
      ptr_q       <= ptr_d;
      pass_q      <= pass_d;
      timed_out_q <= timed_out_d;
      fail_idx_q  <= fail_idx_d;
      fail_got_q  <= fail_got_d;
    end
  end

  // Sequencing: table loads and start in IDLE/DONE, a one-cycle wipe, the
  // capture phase, then one table entry per cycle until a mismatch or the end.
  always_comb begin
    state_d     = state_q;
    wr_count_d  = wr_count_q;
    timer_d     = timer_q;
    ptr_d       = ptr_q;
    pass_d      = pass_q;
    timed_out_d = timed_out_q;
    fail_idx_d  = fail_idx_q;
    fail_got_d  = fail_got_q;
    shadow_clr  = 1'b0;
    shadow_we   = 1'b0;
    tbl_we      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        tbl_we = chk_wr && chk_idx_ok;
        if (start) begin
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        shadow_clr  = 1'b1;
        wr_count_d  = '0;
        timer_d     = '0;
        ptr_d       = '0;
        pass_d      = 1'b0;
        timed_out_d = 1'b0;
        fail_idx_d  = '0;
        fail_got_d  = '0;
        state_d     = S_RUN;
      end

      S_RUN: begin
        if (wb_accept) begin
          shadow_we = 1'b1;
          if (wr_count_q != 16'hFFFF) begin
            wr_count_d = wr_count_q + 16'd1;
          end
        end
        timer_d = timer_q + TW'(1);
        // halt wins over the budget when both land on the same cycle.
        if (halt) begin
          state_d = S_CHECK;
        end else if (timer_q == TimeoutLast) begin
          state_d     = S_CHECK;
          timed_out_d = 1'b1;
        end
      end

      S_CHECK: begin
        if (cur_mismatch) begin
          fail_idx_d = ptr_q;
          fail_got_d = cur_val;
          pass_d     = 1'b0;
          state_d    = S_DONE;
        end else if (ptr_q == LastCheck) begin
          pass_d  = !timed_out_q;
          state_d = S_DONE;
        end else begin
          ptr_d = ptr_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Shadow register file: wiped at the start of every run, then follows the
  // processor's accepted writebacks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (shadow_clr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (shadow_we) begin
      shadow_q[wb_reg] <= wb_data;
    end
  end

  // Expected-value table. It survives across runs and is cleared only by
  // reset; a write with chk_valid low empties the entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        tbl_valid_q[i] <= 1'b0;
        tbl_reg_q[i]   <= '0;
        tbl_exp_q[i]   <= '0;
      end
    end else if (tbl_we) begin
      tbl_valid_q[chk_idx] <= chk_valid;
      tbl_reg_q[chk_idx]   <= chk_valid ? chk_reg : '0;
      tbl_exp_q[chk_idx]   <= chk_valid ? chk_exp : '0;
    end
  end

  assign busy      = (state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign timed_out = timed_out_q;
  assign fail_idx  = fail_idx_q;
  assign fail_got  = fail_got_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_wb_shadow_checker.sv
// tb_wb_shadow_checker
//   Self-checking bench for wb_shadow_checker. Directed writeback vectors,
//   hand-built multi-cycle sequences and randomized runs, all compared
//   against a run-level reference model (shadow array, expected table and
//   a first-mismatch scan) kept in the bench.
module tb_wb_shadow_checker;

  localparam int NumRegs   = 32;
  localparam int DataWidth = 32;
  localparam int NumChecks = 16;
  localparam int Timeout   = 200;

  logic        clock;
  logic        reset;
  logic        start;
  logic        halt;
  logic        wbEn;
  logic [4:0]  wbReg;
  logic [31:0] wbData;
  logic        chkWr;
  logic [3:0]  chkIdx;
  logic        chkValid;
  logic [4:0]  chkReg;
  logic [31:0] chkExp;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timedOut;
  logic [3:0]  failIdx;
  logic [31:0] failGot;
  logic [15:0] wrCount;

  int testsRun;
  int testsFailed;
  int cycles;

  // Reference model state.
  bit          mdlValid  [NumChecks];
  int          mdlReg    [NumChecks];
  logic [31:0] mdlExp    [NumChecks];
  logic [31:0] mdlShadow [NumRegs];
  int          mdlCount;
  bit          mdlTimedOut;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    logic [15:0] expCount;
  } wbVec_t;

  wbVec_t vecs [6];

  wb_shadow_checker #(
    .NUM_REGS  (NumRegs),
    .DATA_WIDTH(DataWidth),
    .NUM_CHECKS(NumChecks),
    .TIMEOUT   (Timeout)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .halt     (halt),
    .wb_en    (wbEn),
    .wb_reg   (wbReg),
    .wb_data  (wbData),
    .chk_wr   (chkWr),
    .chk_idx  (chkIdx),
    .chk_valid(chkValid),
    .chk_reg  (chkReg),
    .chk_exp  (chkExp),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .timed_out(timedOut),
    .fail_idx (failIdx),
    .fail_got (failGot),
    .wr_count (wrCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop so a wedged DUT can never hang the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cycles++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic loadEntry(input int idx, input bit v, input int r, input logic [31:0] e);
    chkWr    = 1'b1;
    chkIdx   = 4'(idx);
    chkValid = v;
    chkReg   = 5'(r);
    chkExp   = e;
    tick();
    chkWr = 1'b0;
    mdlValid[idx] = v;
    mdlReg[idx]   = v ? r : 0;
    mdlExp[idx]   = v ? e : 32'd0;
  endtask

  task automatic modelNewRun();
    for (int i = 0; i < NumRegs; i++) mdlShadow[i] = 32'd0;
    mdlCount    = 0;
    mdlTimedOut = 1'b0;
  endtask

  // Start pulse, then the CLEAR cycle; returns with the DUT in RUN.
  task automatic startRun();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    modelNewRun();
  endtask

  // One RUN cycle with optional writeback and halt.
  task automatic applyStimulus(input logic en, input logic [4:0] r, input logic [31:0] d, input logic h);
    wbEn   = en;
    wbReg  = r;
    wbData = d;
    halt   = h;
    tick();
    wbEn = 1'b0;
    halt = 1'b0;
    if (en && r != 5'd0) begin
      mdlShadow[r] = d;
      if (mdlCount < 65535) mdlCount++;
    end
  endtask

  task automatic waitDone(input string name, input int bound);
    int n;
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    testsRun++;
    if (done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL %s wait: done=%b after %0d cycles, expected 1", name, done, n);
    end
  endtask

  // Scan the expected table in order; the first valid entry whose shadow
  // value differs decides the verdict.
  task automatic checkResults(input string tag);
    logic        expPass;
    logic [31:0] expIdx;
    logic [31:0] expGot;
    bit          found;
    found   = 1'b0;
    expPass = !mdlTimedOut;
    expIdx  = 32'd0;
    expGot  = 32'd0;
    for (int i = 0; i < NumChecks; i++) begin
      if (!found && mdlValid[i] && mdlShadow[mdlReg[i]] != mdlExp[i]) begin
        found   = 1'b1;
        expPass = 1'b0;
        expIdx  = 32'(i);
        expGot  = mdlShadow[mdlReg[i]];
      end
    end
    checkOutput({tag, " done"},      32'(done),     32'd1);
    checkOutput({tag, " busy"},      32'(busy),     32'd0);
    checkOutput({tag, " pass"},      32'(pass),     32'(expPass));
    checkOutput({tag, " timed_out"}, 32'(timedOut), 32'(mdlTimedOut));
    checkOutput({tag, " fail_idx"},  32'(failIdx),  expIdx);
    checkOutput({tag, " fail_got"},  failGot,       expGot);
    checkOutput({tag, " wr_count"},  32'(wrCount),  32'(mdlCount));
  endtask

  initial begin
    int c0;
    int len;
    int nLoads;

    testsRun    = 0;
    testsFailed = 0;
    cycles      = 0;
    reset    = 1'b0;
    start    = 1'b0;
    halt     = 1'b0;
    wbEn     = 1'b0;
    wbReg    = '0;
    wbData   = '0;
    chkWr    = 1'b0;
    chkIdx   = '0;
    chkValid = 1'b0;
    chkReg   = '0;
    chkExp   = '0;
    for (int i = 0; i < NumChecks; i++) begin
      mdlValid[i] = 1'b0;
      mdlReg[i]   = 0;
      mdlExp[i]   = 32'd0;
    end
    modelNewRun();

    vecs[0] = '{5'd1,  32'd5,      16'd1};
    vecs[1] = '{5'd2,  32'd10,     16'd2};
    vecs[2] = '{5'd0,  32'hDEAD,   16'd2};
    vecs[3] = '{5'd5,  32'd100,    16'd3};
    vecs[4] = '{5'd10, 32'h48,     16'd4};
    vecs[5] = '{5'd30, 32'd100,    16'd5};

    // Reset state.
    tick();
    tick();
    checkOutput("reset busy",      32'(busy),     32'd0);
    checkOutput("reset done",      32'(done),     32'd0);
    checkOutput("reset pass",      32'(pass),     32'd0);
    checkOutput("reset timed_out", 32'(timedOut), 32'd0);
    checkOutput("reset wr_count",  32'(wrCount),  32'd0);
    #4 reset = 1'b1;
    tick();

    // Basic pass run, including a writeback to r0 and an r0==0 entry.
    loadEntry(0, 1'b1, 1,  32'd5);
    loadEntry(1, 1'b1, 2,  32'd10);
    loadEntry(2, 1'b1, 5,  32'd100);
    loadEntry(3, 1'b1, 10, 32'h48);
    loadEntry(4, 1'b1, 30, 32'd100);
    loadEntry(5, 1'b1, 0,  32'd0);
    startRun();
    checkOutput("t1 busy in run", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecs[i].r, vecs[i].d, 1'b0);
      checkOutput($sformatf("t1 vec%0d wr_count", i), 32'(wrCount), 32'(vecs[i].expCount));
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    for (int i = 0; i < NumChecks - 1; i++) tick();
    checkOutput("t1 done early", 32'(done), 32'd0);
    tick();
    checkOutput("t1 done latency", 32'(done), 32'd1);
    checkResults("t1");
    checkOutput("t1 pass const", 32'(pass), 32'd1);
    checkOutput("t1 wr_count const", 32'(wrCount), 32'd5);

    // Mismatch at entry 3 stops the scan there.
    loadEntry(3, 1'b1, 6, 32'd200);
    startRun();
    applyStimulus(1'b1, 5'd1,  32'd5,   1'b0);
    applyStimulus(1'b1, 5'd2,  32'd10,  1'b0);
    applyStimulus(1'b1, 5'd5,  32'd100, 1'b0);
    applyStimulus(1'b1, 5'd6,  32'd199, 1'b0);
    applyStimulus(1'b1, 5'd30, 32'd100, 1'b0);
    applyStimulus(1'b0, 5'd0,  32'd0,   1'b1);
    tick();
    tick();
    tick();
    checkOutput("t2 done early", 32'(done), 32'd0);
    tick();
    checkOutput("t2 done at entry 3", 32'(done), 32'd1);
    checkResults("t2");
    checkOutput("t2 fail_idx const", 32'(failIdx), 32'd3);
    checkOutput("t2 fail_got const", failGot, 32'd199);

    // Timeout with every entry matching.
    startRun();
    c0 = cycles;
    applyStimulus(1'b1, 5'd1,  32'd5,   1'b0);
    applyStimulus(1'b1, 5'd2,  32'd10,  1'b0);
    applyStimulus(1'b1, 5'd5,  32'd100, 1'b0);
    applyStimulus(1'b1, 5'd6,  32'd200, 1'b0);
    applyStimulus(1'b1, 5'd30, 32'd100, 1'b0);
    waitDone("t4", Timeout + NumChecks + 8);
    mdlTimedOut = 1'b1;
    checkOutput("t4 latency", 32'(cycles - c0), 32'(Timeout + NumChecks));
    checkResults("t4");
    checkOutput("t4 pass const", 32'(pass), 32'd0);

    // Writeback on the halt cycle; start in RUN and chk_wr in CHECK ignored.
    loadEntry(6, 1'b1, 7, 32'd300);
    startRun();
    applyStimulus(1'b1, 5'd1,  32'd5,   1'b0);
    applyStimulus(1'b1, 5'd2,  32'd10,  1'b0);
    applyStimulus(1'b1, 5'd5,  32'd100, 1'b0);
    applyStimulus(1'b1, 5'd6,  32'd200, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("t5 busy after start", 32'(busy), 32'd1);
    applyStimulus(1'b1, 5'd30, 32'd100, 1'b0);
    applyStimulus(1'b1, 5'd7,  32'd300, 1'b1);
    chkWr    = 1'b1;
    chkIdx   = 4'd15;
    chkValid = 1'b1;
    chkReg   = 5'd1;
    chkExp   = 32'd999;
    tick();
    chkWr = 1'b0;
    waitDone("t5", NumChecks + 4);
    checkResults("t5");
    checkOutput("t5 pass const", 32'(pass), 32'd1);

    // start and chk_wr together in DONE: both take effect.
    chkWr    = 1'b1;
    chkIdx   = 4'd7;
    chkValid = 1'b1;
    chkReg   = 5'd3;
    chkExp   = 32'd77;
    start    = 1'b1;
    tick();
    chkWr = 1'b0;
    start = 1'b0;
    mdlValid[7] = 1'b1;
    mdlReg[7]   = 3;
    mdlExp[7]   = 32'd77;
    tick();
    modelNewRun();
    applyStimulus(1'b1, 5'd1,  32'd5,   1'b0);
    applyStimulus(1'b1, 5'd2,  32'd10,  1'b0);
    applyStimulus(1'b1, 5'd5,  32'd100, 1'b0);
    applyStimulus(1'b1, 5'd6,  32'd200, 1'b0);
    applyStimulus(1'b1, 5'd30, 32'd100, 1'b0);
    applyStimulus(1'b1, 5'd7,  32'd300, 1'b0);
    applyStimulus(1'b1, 5'd3,  32'd76,  1'b1);
    waitDone("t5b", NumChecks + 4);
    checkResults("t5b");

    // Reset mid-RUN clears everything including the table.
    startRun();
    applyStimulus(1'b1, 5'd1, 32'd5, 1'b0);
    #2 reset = 1'b0;
    #1;
    checkOutput("t6 busy in reset",     32'(busy),    32'd0);
    checkOutput("t6 done in reset",     32'(done),    32'd0);
    checkOutput("t6 wr_count in reset", 32'(wrCount), 32'd0);
    #1 reset = 1'b1;
    for (int i = 0; i < NumChecks; i++) begin
      mdlValid[i] = 1'b0;
      mdlReg[i]   = 0;
      mdlExp[i]   = 32'd0;
    end
    tick();
    startRun();
    applyStimulus(1'b1, 5'd1, 32'd1, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    waitDone("t6", NumChecks + 4);
    checkResults("t6");
    checkOutput("t6 pass const", 32'(pass), 32'd1);

    // Randomized runs against the reference model.
    for (int run = 0; run < 16; run++) begin
      nLoads = int'($urandom_range(1, 4));
      for (int k = 0; k < nLoads; k++) begin
        loadEntry(int'($urandom_range(0, NumChecks - 1)), $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, NumRegs - 1)), 32'($urandom_range(0, 3)));
      end
      startRun();
      if (run % 5 == 4) begin
        for (int c = 0; c < Timeout; c++) begin
          applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, NumRegs - 1)),
                        32'($urandom_range(0, 3)), 1'b0);
        end
        mdlTimedOut = 1'b1;
      end else begin
        len = int'($urandom_range(1, 30));
        for (int c = 0; c < len; c++) begin
          applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, NumRegs - 1)),
                        32'($urandom_range(0, 3)), c == len - 1);
        end
      end
      waitDone($sformatf("rand%0d", run), NumChecks + 4);
      checkResults($sformatf("rand%0d", run));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
